// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
//   state_t       : decoder FSM states (WARMUP, RUN)
//   PH_*          : the four {a,b} phase codes
//   WARMUP_CYCLES : cycles after reset release before detection starts
//   next_up()     : phase that follows a given phase in the up direction
package quad_pkg;

  typedef enum logic {WARMUP, RUN} state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam int WARMUP_CYCLES = 3;
  localparam int COUNT_W       = 4;

  // Up order is 00 -> 10 -> 11 -> 01 -> 00; down is the reverse, so a move
  // prev -> cur is "down" exactly when next_up(cur) == prev.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
//   clk   : destination clock
//   reset : synchronous reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder decoder with position counter.
//   clk, reset : clock and synchronous active-high reset
//   ena        : 1 = decoded steps move count / raise error
//   quad_a/b   : asynchronous encoder channels
//   set        : load count from set_value at the next edge
//   set_value  : value loaded by set
//   clear_err  : clears the sticky error flag
//   step       : one-cycle pulse per valid transition (ena=1)
//   up_down    : direction of the last valid transition, 1 = up
//   count      : position counter, wraps modulo 16
//   error      : sticky flag for two-bit (illegal) phase jumps
module quad_decoder
  import quad_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               quad_a,
  input  logic               quad_b,
  input  logic               set,
  input  logic [COUNT_W-1:0] set_value,
  input  logic               clear_err,
  output logic               step,
  output logic               up_down,
  output logic [COUNT_W-1:0] count,
  output logic               error
);

  logic       a_p1;
  logic       b_p1;
  logic [1:0] phase_p1;
  logic [1:0] prev_p2;
  logic [1:0] wcnt;
  state_t     state;
  logic       is_up;
  logic       is_dn;
  logic       is_ill;
  logic       moved;

  sync_2ff u_sync_a (.clk(clk), .reset(reset), .d(quad_a), .q(a_p1));
  sync_2ff u_sync_b (.clk(clk), .reset(reset), .d(quad_b), .q(b_p1));

  // Synchronized phase vs. phase seen on the previous cycle
  assign phase_p1 = {a_p1, b_p1};

  always_comb begin
    is_up  = (phase_p1 == next_up(prev_p2));
    is_dn  = (prev_p2 == next_up(phase_p1));
    is_ill = (phase_p1 != prev_p2) && !is_up && !is_dn;
    moved  = (state == RUN) && (is_up || is_dn);
  end

  // Registered decode results
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_p2 <= 2'b00;
      wcnt    <= 2'd0;
      state   <= WARMUP;
      step    <= 1'b0;
      up_down <= 1'b0;
      count   <= '0;
      error   <= 1'b0;
    end else begin
      // Tracking continues through warmup and with ena=0 so that the first
      // detected transition is always relative to a real pin history.
      prev_p2 <= phase_p1;
      step    <= moved && ena;

      if (state == WARMUP) begin
        if (wcnt == 2'(WARMUP_CYCLES - 1)) state <= RUN;
        else                               wcnt  <= wcnt + 2'd1;
      end

      if (moved) up_down <= is_up;

      if (set)
        count <= set_value;
      else if (moved && ena)
        count <= is_up ? count + 4'd1 : count - 4'd1;

      // A same-cycle illegal jump beats clear_err.
      if ((state == RUN) && ena && is_ill) error <= 1'b1;
      else if (clear_err)                  error <= 1'b0;
    end
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Ports SHALL be as listed; clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ena  input  1  1 = decoded steps update count; 0 = count held.
REQ-005 quad_a  input  1  encoder channel A; asynchronous to clk.
REQ-006 quad_b  input  1  encoder channel B; asynchronous to clk.
REQ-007 set  input  1  load request; count <= set_value at next edge.
REQ-008 set_value  input  4  value loaded by set.
REQ-009 clear_err  input  1  clears sticky error flag.
REQ-010 step  output  1  one-cycle pulse per valid quadrature transition.
REQ-011 up_down  output  1  direction of last valid transition: 1 = up, 0 = down.
REQ-012 count  output  4  position counter.
REQ-013 error  output  1  sticky illegal-transition flag.

Function
REQ-014 quad_a and quad_b SHALL each pass through a 2-flop synchronizer; raw pins feed no other logic.
REQ-015 Phase code {a,b}: up sequence 00->10->11->01->00; down is the reverse.
REQ-016 Latency: pin change first captured at edge N -> step and count update registered at edge N+2.
REQ-017 Prev-phase register SHALL load the synchronized phase every RUN cycle, whatever the transition type.
REQ-018 Single-bit phase change in up order: step=1 for one cycle, up_down=1, count+1 if ena.
REQ-019 Single-bit phase change in down order: step=1 for one cycle, up_down=0, count-1 if ena.
REQ-020 No phase change: step=0; up_down and count hold.
REQ-021 Two-bit phase change (illegal): step=0, count and up_down unchanged, error<=1 if ena.
REQ-022 ena=0: step, count and error updates suppressed; prev-phase tracking continues.
REQ-023 Count wraps modulo 16: 15 up -> 0, 0 down -> 15.
REQ-024 set=1 SHALL load count=set_value regardless of ena or a simultaneous step; step/up_down still reported.
REQ-025 clear_err=1 SHALL clear error, except an illegal transition in the same cycle keeps error=1.
REQ-026 FSM states: WARMUP, RUN.
REQ-027 WARMUP lasts exactly 3 cycles after reset deasserts: prev-phase follows synchronized phase, no detection, step=0; then RUN.
REQ-028 RUN persists until reset.

Reset
REQ-029 reset=1 at an edge SHALL set count=0, step=0, up_down=0, error=0, synchronizers=0, prev-phase=0, state=WARMUP, warmup counter=0.
REQ-030 Reset SHALL take priority over set, clear_err and ena; reset mid-operation discards in-flight transitions.
REQ-031 No spurious step or error SHALL occur after reset release, whatever the static pin levels.

Structure
REQ-032 Package quad_pkg SHALL hold the FSM state typedef, the four phase-code constants and WARMUP_CYCLES=3.
REQ-033 Sub-module sync_2ff (1-bit two-flop synchronizer with synchronous reset) SHALL be instantiated twice.
REQ-034 All outputs SHALL be driven directly from flops.

Verification
REQ-035 Reset, pins held 11, ena=1 for 10 cycles -> count=0, step never 1, error=0.
REQ-036 From count=0, ena=1, drive 4 up-order phase steps, 4 cycles apart -> 4 step pulses, up_down=1, count=4; each pulse 2 edges after capture.
REQ-037 set_value=0, set=1 pulse, then 1 down step -> count=15, up_down=0.
REQ-038 Phase 00->11 directly -> error=1, step=0, count unchanged; clear_err=1 for 1 cycle -> error=0.
REQ-039 ena=0 with 3 up steps -> count unchanged, no step; then ena=1 and 1 up step -> count+1.
REQ-040 Simultaneous set (set_value=9) and an up step -> count=9, step=1; reset asserted mid-sequence -> count=0 next edge.
